// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input
// and decode-side instruction handshake.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, decode_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, decode_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word fetch into an in-order FIFO with redirect flush.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_CNT = cnt_t'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  cnt_t          outstanding;
  cnt_t          drop_cnt;
  cnt_t          count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   redirect_base;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          head_valid;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;

  always_comb begin
    redirect_base = bus.redirect_pc & ~32'h0000_0003;
    credit_used   = {1'b0, outstanding} + {1'b0, count};
    // Counting in-flight requests against free slots guarantees every kept response has room.
    req_valid     = rst_n && !bus.redirect_valid && (credit_used < {1'b0, DEPTH_CNT});
    req_fire      = req_valid && bus.imem_req_ready;
    rsp_fire      = bus.imem_rsp_valid && (outstanding != '0);
    rsp_keep      = rsp_fire && (drop_cnt == '0);
    head_valid    = (count != '0);
`ifdef FETCH_BYPASS_EN
    bypass        = rsp_keep && !head_valid && bus.decode_ready && !bus.redirect_valid;
`else
    bypass        = 1'b0;
`endif
    push          = rsp_keep && !bypass && !bus.redirect_valid;
    pop           = head_valid && bus.decode_ready;
  end

  always_comb begin
    out_valid = 1'b0;
    out_instr = '0;
    out_pc    = '0;
    if (head_valid) begin
      out_valid = 1'b1;
      out_instr = fifo_instr[rd_ptr];
      out_pc    = fifo_pc[rd_ptr];
    end else if (bypass) begin
      out_valid = 1'b1;
      out_instr = bus.imem_rsp_data;
      out_pc    = rsp_pc;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc;
  assign bus.instr_valid    = out_valid;
  assign bus.instr          = out_instr;
  assign bus.instr_pc       = out_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.redirect_valid) begin
      // A response landing in the redirect cycle is consumed here, so only the rest get dropped.
      fetch_pc    <= redirect_base;
      rsp_pc      <= redirect_base;
      outstanding <= outstanding - cnt_t'(rsp_fire);
      drop_cnt    <= outstanding - cnt_t'(rsp_fire);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_keep) rsp_pc <= rsp_pc + 32'd4;
      outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_fire);
      if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - cnt_t'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_instr[wr_ptr] <= bus.imem_rsp_data;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end
endmodule
